// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared definitions for the sequential shift-add multiplier:
//            FSM state encoding, default operand width, iteration count.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Controller states of the multiplier
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Default operand width; the product is twice this wide
    localparam int c_default_word_size = 8;

    // One radix-2 iteration per operand bit
    function automatic int iter_count(input int width);
        return width;
    endfunction

    localparam int c_iter_count = iter_count(c_default_word_size);

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier_if
// Purpose  : Start/operand/result bundle of the sequential multiplier.
//            master = requester driving operands, slave = multiplier core.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if
    import mul_pkg::*;
#(
    parameter int word_size = c_default_word_size
);
    logic                 start;
    logic [word_size-1:0] op_a;
    logic [word_size-1:0] op_b;
    logic                 busy;
    logic                 done;
    logic [word_size-1:0] product_lsb;
    logic [word_size-1:0] product_msb;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product_lsb, product_msb
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product_lsb, product_msb
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Radix-2 shift-add multiplier, one iteration per clock for
//            word_size clocks, followed by a one-cycle done pulse.
//            Define MUL_SIGNED_EN for two's-complement operands (multiplicand
//            sign-extended, last partial product subtracted); otherwise the
//            operands are unsigned. Latency is the same in both builds.
//            Reset (rst) is asynchronous and active-low.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int word_size = c_default_word_size
) (
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);

    localparam int c_iters  = iter_count(word_size);
    localparam int c_cnt_w  = (c_iters > 1) ? $clog2(c_iters) : 1;
    localparam int c_prod_w = 2 * word_size;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(c_iters - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_capture;
    logic                  w_iterate;
    logic                  w_last;
    logic                  w_sub;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_prod_w-1:0]   r_acc;
    logic [c_prod_w-1:0]   r_mcand;
    logic [word_size-1:0]  r_mplier;
    logic [c_prod_w-1:0]   w_mcand_ext;
    logic [c_prod_w-1:0]   w_acc_next;

    assign w_last = (r_count == c_last_iter);

    // State register; reset aborts any multiply in flight immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and status outputs; start only matters in IDLE
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_iterate    = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_capture    = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                bus.busy  = 1'b1;
                w_iterate = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.done     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand extension and one shift-add step of the accumulator
    always_comb begin
`ifdef MUL_SIGNED_EN
        // The multiplier MSB carries weight -2^(w-1), so its partial
        // product is subtracted on the final iteration.
        w_mcand_ext = {{word_size{bus.op_a[word_size-1]}}, bus.op_a};
        w_sub       = w_last;
`else
        w_mcand_ext = {{word_size{1'b0}}, bus.op_a};
        w_sub       = 1'b0;
`endif
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = w_sub ? (r_acc - r_mcand) : (r_acc + r_mcand);
        end
    end

    // Datapath: capture operands on start, then iterate once per BUSY clock.
    // The accumulator is left untouched in DONE/IDLE so the result holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_capture) begin
            r_acc    <= '0;
            r_mcand  <= w_mcand_ext;
            r_mplier <= bus.op_b;
            r_count  <= '0;
        end else if (w_iterate) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[c_prod_w-2:0], 1'b0};
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    assign bus.product_lsb = r_acc[word_size-1:0];
    assign bus.product_msb = r_acc[c_prod_w-1:word_size];

endmodule
`default_nettype wire

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: word_size, 8, operand width in bits; the product is 2*word_size bits.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to capture operands and begin a multiply.
REQ-005 SHALL have port: op_a  input  word_size  multiplicand, taken from the source register.
REQ-006 SHALL have port: op_b  input  word_size  multiplier, taken from the destination register.
REQ-007 SHALL have port: busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the product is valid.
REQ-009 SHALL have port: product_lsb  output  word_size  low half of the product, written back to the source register.
REQ-010 SHALL have port: product_msb  output  word_size  high half of the product, written back to the destination register.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-012 In IDLE with start=1, SHALL capture op_a and op_b, clear the accumulator and iteration counter, and go to BUSY on that edge.
REQ-013 In BUSY, SHALL perform one radix-2 shift-add iteration per clock for exactly word_size clocks, using the counter 0..word_size-1.
REQ-014 After the last iteration, SHALL go to DONE, assert done for exactly one cycle, then return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle that begins word_size edges after the start-capture edge (8 for the default).
REQ-016 busy SHALL be high in BUSY only; done SHALL be high in DONE only.
REQ-017 product_lsb and product_msb SHALL be valid when done=1, and SHALL be held stable until the next start is accepted.
REQ-018 start SHALL be ignored in BUSY and DONE; no operand recapture, no restart.
REQ-019 The unsigned product SHALL be exact, with no overflow: 2*word_size bits hold the maximum (2^w-1)^2.
REQ-020 Operands of zero SHALL still take the full latency; there is no early termination.
REQ-021 Changes on op_a or op_b after the capture edge SHALL NOT affect the result.

Reset
REQ-022 While rst=0, SHALL force state IDLE, with busy=0, done=0, product_lsb=0, product_msb=0, and the counter and internal registers at 0.
REQ-023 Reset asserted mid-operation SHALL abort the multiply immediately, without waiting for a clock edge; no done pulse follows.
REQ-024 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-025 The macro MUL_SIGNED_EN SHALL select the operand arithmetic.
REQ-026 With MUL_SIGNED_EN defined, operands SHALL be two's complement. The multiplicand is sign-extended, and the final iteration subtracts the partial product when the op_b MSB is 1. Latency is unchanged.
REQ-027 Without MUL_SIGNED_EN, operands SHALL be unsigned.

Structure
REQ-028 A shared package mul_pkg SHALL hold the FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the default word size, and the iteration-count constant.
REQ-029 SHALL be a single module with no sub-module; the counter, accumulator and FSM are all local.

Verification
REQ-030 op_a=5, op_b=6, one-cycle start -> done 8 cycles after capture; product_msb=0x00, product_lsb=0x1E.
REQ-031 op_a=255, op_b=255, unsigned build -> product_msb=0xFE, product_lsb=0x01.
REQ-032 start pulsed again 3 cycles into a busy multiply with new operands -> ignored; the original product is reported and only one done pulse occurs.
REQ-033 rst driven low 4 cycles after start -> busy=0, outputs are 0 with no clock edge needed, and no done; a new start 5*6 then completes normally.
REQ-034 MUL_SIGNED_EN build, op_a=0xFE (-2), op_b=0x03 -> product_msb=0xFF, product_lsb=0xFA; op_a=0x80, op_b=0x80 -> 0x4000.
REQ-035 op_a=0, op_b=0x7F -> product is 0 after the full 8-cycle latency, and the outputs hold through 5 idle cycles.
